// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch stage and its jump LUT.
//   fetch_state_t : fetch FSM states (IDLE, RUN, DONE)
//   HALT_OP       : instruction word that stops the run
//   LUT_DEPTH     : number of jump-target entries
//   LUT_PTR_W     : width of the LUT index / relative offset
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
    localparam logic [8:0] HALT_OP = 9'h1FF;
    localparam int LUT_DEPTH = 16;
    localparam int LUT_PTR_W = 4;
endpackage

// File: rtl/jump_lut.sv
// jump_lut: 16-entry jump-target register file, sync write, async read.
//   clk, reset          : clock, asynchronous active-high reset (clears all entries)
//   wr_en/addr/data     : write port, takes effect on the rising edge
//   rd_addr -> rd_data  : combinational read port
module jump_lut
    import cpu_pkg::*;
#(
    parameter int W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [LUT_PTR_W-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic [LUT_PTR_W-1:0] rd_addr,
    output logic [W-1:0]         rd_data
);
    logic [W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection, run FSM and cycle counter.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : run request, honoured in IDLE or DONE
//   done, running         : FSM status; running gates architectural writes
//   instr_addr            : registered PC driving the instruction ROM
//   instr_in              : ROM word at instr_addr
//   pc_jmp_en/abs, lut_ptr: jump request from the decoder
//   lut_wr_en/addr/data   : jump-target table write port (ignored in RUN)
//   cycle_cnt             : saturating count of RUN cycles since last start
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    output logic                 running,
    output logic [PC_W-1:0]      instr_addr,
    input  logic [8:0]           instr_in,
    input  logic                 pc_jmp_en,
    input  logic                 pc_jmp_abs,
    input  logic [LUT_PTR_W-1:0] lut_ptr,
    input  logic                 lut_wr_en,
    input  logic [LUT_PTR_W-1:0] lut_wr_addr,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [15:0]          cycle_cnt
);
    fetch_state_t    state;
    logic [PC_W-1:0] lut_target;
    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] next_pc;

    jump_lut #(.W(PC_W)) u_lut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (lut_wr_en && state != RUN),
        .wr_addr (lut_wr_addr),
        .wr_data (lut_wr_data),
        .rd_addr (lut_ptr),
        .rd_data (lut_target)
    );

    // lut_ptr doubles as a signed -8..+7 offset for relative jumps
    assign rel_off = {{(PC_W-LUT_PTR_W){lut_ptr[LUT_PTR_W-1]}}, lut_ptr};
    assign next_pc = !pc_jmp_en ? instr_addr + PC_W'(1) :
                     pc_jmp_abs ? lut_target : instr_addr + rel_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            instr_addr <= START_ADDR;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            running    <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                state      <= RUN;
                instr_addr <= START_ADDR;
                cycle_cnt  <= '0;
                done       <= 1'b0;
                running    <= 1'b1;
            end
        end else begin
            cycle_cnt <= (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
            // halt wins over any jump: PC freezes on the halt word
            if (instr_in == HALT_OP) begin
                state   <= DONE;
                done    <= 1'b1;
                running <= 1'b0;
            end else begin
                instr_addr <= next_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector bench for fetch_unit.
module tb_fetch_unit;
    typedef struct {
        logic        st;
        logic [8:0]  ins;
        logic        je;
        logic        ja;
        logic [3:0]  p;
        logic        we;
        logic [3:0]  wa;
        logic [9:0]  wd;
        logic [9:0]  ea;
        logic        ed;
        logic        er;
        logic [15:0] ec;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        done, running;
    logic [9:0]  instr_addr;
    logic [8:0]  instr_in = 0;
    logic        pc_jmp_en = 0, pc_jmp_abs = 0;
    logic [3:0]  lut_ptr = 0;
    logic        lut_wr_en = 0;
    logic [3:0]  lut_wr_addr = 0;
    logic [9:0]  lut_wr_data = 0;
    logic [15:0] cycle_cnt;

    int passed = 0;
    int total = 0;
    vec_t v[$];

    fetch_unit #(.PC_W(10), .START_ADDR(10'h000)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .running(running),
        .instr_addr(instr_addr), .instr_in(instr_in), .pc_jmp_en(pc_jmp_en),
        .pc_jmp_abs(pc_jmp_abs), .lut_ptr(lut_ptr), .lut_wr_en(lut_wr_en),
        .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic st, logic [8:0] ins, logic je, logic ja, logic [3:0] p,
                                logic we, logic [3:0] wa, logic [9:0] wd,
                                logic [9:0] ea, logic ed, logic er, logic [15:0] ec);
        vec_t r;
        r.st = st; r.ins = ins; r.je = je; r.ja = ja; r.p = p;
        r.we = we; r.wa = wa; r.wd = wd;
        r.ea = ea; r.ed = ed; r.er = er; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    task automatic chk_all(input string tag, input vec_t r);
        chk({tag, " instr_addr"}, 32'(instr_addr), 32'(r.ea));
        chk({tag, " done"},       32'(done),       32'(r.ed));
        chk({tag, " running"},    32'(running),    32'(r.er));
        chk({tag, " cycle_cnt"},  32'(cycle_cnt),  32'(r.ec));
    endtask

    // drive a row, clock it in, and compare 1 time unit after the edge
    task automatic apply(input string tag, input vec_t r);
        start = r.st; instr_in = r.ins; pc_jmp_en = r.je; pc_jmp_abs = r.ja; lut_ptr = r.p;
        lut_wr_en = r.we; lut_wr_addr = r.wa; lut_wr_data = r.wd;
        @(posedge clk);
        #1;
        chk_all(tag, r);
    endtask

    initial begin
        // st  ins     je ja p      we wa  wd       ea      ed er ec
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 1, 4'd5, 10'h0A3, 10'h000, 0, 0, 0));
        v.push_back(mk(1, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h000, 0, 1, 0));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h001, 0, 1, 1));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h002, 0, 1, 2));
        v.push_back(mk(0, 9'h000, 1, 1, 4'd5, 0, 4'd0, 10'h000, 10'h0A3, 0, 1, 3));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h0A4, 0, 1, 4));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 1, 4'd3, 10'h155, 10'h0A5, 0, 1, 5));
        v.push_back(mk(0, 9'h1FF, 1, 1, 4'd5, 0, 4'd0, 10'h000, 10'h0A5, 1, 0, 6));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h0A5, 1, 0, 6));
        v.push_back(mk(1, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h000, 0, 1, 0));
        v.push_back(mk(0, 9'h000, 1, 1, 4'd3, 0, 4'd0, 10'h000, 10'h000, 0, 1, 1));
        v.push_back(mk(0, 9'h000, 1, 0, 4'd7, 0, 4'd0, 10'h000, 10'h007, 0, 1, 2));
        v.push_back(mk(1, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h008, 0, 1, 3));
        v.push_back(mk(0, 9'h1FF, 1, 0, 4'd1, 0, 4'd0, 10'h000, 10'h008, 1, 0, 4));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 1, 4'd3, 10'h155, 10'h008, 1, 0, 4));
        v.push_back(mk(1, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h000, 0, 1, 0));
        v.push_back(mk(0, 9'h000, 1, 1, 4'd3, 0, 4'd0, 10'h000, 10'h155, 0, 1, 1));
        v.push_back(mk(0, 9'h000, 1, 0, 4'h8, 0, 4'd0, 10'h000, 10'h14D, 0, 1, 2));
        v.push_back(mk(0, 9'h1FF, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h14D, 1, 0, 3));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 1, 4'd1, 10'h3FF, 10'h14D, 1, 0, 3));
        v.push_back(mk(1, 9'h000, 0, 0, 4'h0, 1, 4'd2, 10'h010, 10'h000, 0, 1, 0));
        v.push_back(mk(0, 9'h000, 1, 1, 4'd1, 0, 4'd0, 10'h000, 10'h3FF, 0, 1, 1));
        v.push_back(mk(0, 9'h000, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h000, 0, 1, 2));
        v.push_back(mk(0, 9'h000, 1, 1, 4'd2, 0, 4'd0, 10'h000, 10'h010, 0, 1, 3));
        v.push_back(mk(0, 9'h000, 1, 0, 4'h8, 0, 4'd0, 10'h000, 10'h008, 0, 1, 4));
        v.push_back(mk(0, 9'h1FF, 0, 0, 4'h0, 0, 4'd0, 10'h000, 10'h008, 1, 0, 5));

        #12 reset = 0;
        chk_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0));

        foreach (v[i]) apply($sformatf("row%0d", i), v[i]);

        // fresh run from DONE: PC 0..7, halt+jump at 7 lands with cycle_cnt 8
        apply("restart", mk(1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0));
        for (int i = 1; i <= 7; i++)
            apply($sformatf("seq%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 10'(i), 0, 1, 16'(i)));
        apply("halt_pri", mk(0, 9'h1FF, 1, 1, 4'd2, 0, 0, 0, 10'h007, 1, 0, 8));
        apply("done_restart", mk(1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0));
        apply("run1", mk(0, 0, 0, 0, 0, 0, 0, 0, 10'h001, 0, 1, 1));
        apply("run2", mk(0, 0, 0, 0, 0, 0, 0, 0, 10'h002, 0, 1, 2));

        // asynchronous reset between edges, then confirm the LUT was cleared
        #3 reset = 1;
        #1 chk_all("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0));
        #2 reset = 0;
        apply("post_reset_start", mk(1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0));
        apply("lut_cleared", mk(0, 0, 1, 1, 4'd1, 0, 0, 0, 10'h000, 0, 1, 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
